bcd2binary: RTL

Sequential 4-digit BCD to 14-bit binary converter using reverse double-dabble: shift right, then subtract 3 from every digit ≥ 8. It is the inverse of the score/timer binary-to-BCD converter. It sits between BCD sources (digit entry, BCD counters, stored high scores) and binary arithmetic in the game logic. Conversion is started by a one-cycle request and signalled by a one-cycle `done` pulse.

---
 rtl/bcd2binary_if.sv | 25 ++
 rtl/bcd2binary.sv | 107 ++++++++++
 2 files changed

// File: rtl/bcd2binary_if.sv
// Signal bundle for the BCD-to-binary converter: request/digit inputs plus result and debug outputs.
// The converter uses the slave modport; whoever drives the request uses master.
interface bcd2binary_if;
    logic        start;
    logic [3:0]  bcd3;
    logic [3:0]  bcd2;
    logic [3:0]  bcd1;
    logic [3:0]  bcd0;
    logic [13:0] bin;
    logic        done;
    logic        busy;
    logic        err;
    logic [3:0]  count;
    logic [2:0]  state;

    modport master (
        output start, bcd3, bcd2, bcd1, bcd0,
        input  bin, done, busy, err, count, state
    );

    modport slave (
        input  start, bcd3, bcd2, bcd1, bcd0,
        output bin, done, busy, err, count, state
    );
endinterface

// File: rtl/bcd2binary.sv
// Sequential 4-digit BCD to 14-bit binary converter (reverse double-dabble).
// Each of the 14 shifts is followed by CHECK and, except after the last, a -3 correction pass.
module bcd2binary (
    input  logic         clk,
    input  logic         reset,
    bcd2binary_if.slave  bus
);
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SHIFT = 3'd1;
    localparam logic [2:0] ST_CHECK = 3'd2;
    localparam logic [2:0] ST_SUB   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]  st_q,   st_d;
    logic [15:0] dig_q,  dig_d;
    logic [13:0] acc_q,  acc_d;
    logic [3:0]  idx_q,  idx_d;
    logic [13:0] bin_q,  bin_d;
    logic        err_q,  err_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        bad_digit;

    assign bad_digit = (bus.bcd3 > 4'd9) || (bus.bcd2 > 4'd9) ||
                       (bus.bcd1 > 4'd9) || (bus.bcd0 > 4'd9);

    always_comb begin
        st_d  = st_q;
        dig_d = dig_q;
        acc_d = acc_q;
        idx_d = idx_q;
        bin_d = bin_q;
        err_d = err_q;
        case (st_q)
            ST_IDLE: begin
                if (bus.start) begin
                    dig_d = {bus.bcd3, bus.bcd2, bus.bcd1, bus.bcd0};
                    acc_d = '0;
                    idx_d = '0;
                    if (bad_digit) begin
                        err_d = 1'b1;
                        bin_d = '0;
                        st_d  = ST_DONE;
                    end else begin
                        err_d = 1'b0;
                        st_d  = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                {dig_d, acc_d} = {1'b0, dig_q, acc_q[13:1]};
                st_d = ST_CHECK;
            end
            ST_CHECK: begin
                if (idx_q == 4'd13) begin
                    bin_d = acc_q;
                    st_d  = ST_DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                    st_d  = ST_SUB;
                end
            end
            ST_SUB: begin
                // A nibble >= 8 after a right shift came from a tens carry; -3 restores the BCD weight.
                for (int n = 0; n < 4; n++) begin
                    if (dig_q[4*n +: 4] >= 4'd8) begin
                        dig_d[4*n +: 4] = dig_q[4*n +: 4] - 4'd3;
                    end
                end
                st_d = ST_SHIFT;
            end
            ST_DONE: st_d = ST_IDLE;
            default: st_d = ST_IDLE;
        endcase
        done_d = (st_d == ST_DONE);
        busy_d = (st_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q   <= ST_IDLE;
            dig_q  <= '0;
            acc_q  <= '0;
            idx_q  <= '0;
            bin_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            dig_q  <= dig_d;
            acc_q  <= acc_d;
            idx_q  <= idx_d;
            bin_q  <= bin_d;
            err_q  <= err_d;
            done_q <= done_d;
            busy_q <= busy_d;
        end
    end

    assign bus.bin   = bin_q;
    assign bus.err   = err_q;
    assign bus.done  = done_q;
    assign bus.busy  = busy_q;
    assign bus.count = idx_q;
    assign bus.state = st_q;
endmodule
